// File: rtl/irq_pkg.sv
// Shared types and default sizing for the external interrupt controller.
package irq_pkg;

    localparam int NIRQ_DEF        = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: multi-flop synchronizer followed by a rising-edge detector.
module irq_sync
    import irq_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   warm_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            warm_q <= {warm_q[STAGES-1:0], 1'b1};
        end
    end

    // The first post-reset sample only primes prev, so a line held high through reset stays quiet.
    assign rise = sync_q[STAGES-1] & ~prev_q & warm_q[STAGES];

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: pending/mask registers, fixed priority
// (line 0 highest) and a non-nesting request/service handshake.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NIRQ        = NIRQ_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NIRQ-1:0]         irq_in,
    input  logic                    mask_we,
    input  logic [NIRQ-1:0]         mask_wdata,
    input  logic                    ExtIAck,
    input  logic                    ERet,
    output logic                    ExtIRQ,
    output logic [$clog2(NIRQ)-1:0] irq_id,
    output logic [NIRQ-1:0]         irq_mask,
    output logic                    irq_lost
);

    localparam int IDW = $clog2(NIRQ);

    state_t          state_q;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] pending_q;
    logic [NIRQ-1:0] active;
    logic [NIRQ-1:0] clr;
    logic [IDW-1:0]  pick;

    for (genvar i = 0; i < NIRQ; i++) begin : g_sync
        irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (irq_in[i]),
            .rise  (rise[i])
        );
    end

    assign active = pending_q & ~irq_mask;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pick = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) pick = IDW'(i);
        end
    end

    always_comb begin
        clr = '0;
        if (state_q == ST_REQ && ExtIAck) clr[irq_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ExtIRQ    <= 1'b0;
            irq_id    <= '0;
            pending_q <= '0;
            irq_mask  <= '1;
            irq_lost  <= 1'b0;
        end else begin
            // A new edge beats a same-cycle acknowledge clear of that line.
            pending_q <= (pending_q & ~clr) | rise;
            if (|(rise & pending_q & ~clr)) irq_lost <= 1'b1;
            if (mask_we) irq_mask <= mask_wdata;

            case (state_q)
                ST_IDLE: begin
                    if (|active) begin
                        state_q <= ST_REQ;
                        ExtIRQ  <= 1'b1;
                        irq_id  <= pick;
                    end
                end
                ST_REQ: begin
                    if (ExtIAck) begin
                        state_q <= ST_SERVICE;
                        ExtIRQ  <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (ERet) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ExtIRQ  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with hand-computed expectations (NIRQ=4, SYNC_STAGES=2).
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       ExtIAck;
    logic       ERet;
    logic       ExtIRQ;
    logic [1:0] irq_id;
    logic [3:0] irq_mask;
    logic       irq_lost;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.NIRQ(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ExtIAck    (ExtIAck),
        .ERet       (ERet),
        .ExtIRQ     (ExtIRQ),
        .irq_id     (irq_id),
        .irq_mask   (irq_mask),
        .irq_lost   (irq_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    // One-cycle pulse sampled at edge k; returns just after edge k.
    task automatic pulse(input logic [3:0] lines);
        irq_in = lines;
        tick();
        irq_in = '0;
    endtask

    task automatic ack();
        ExtIAck = 1'b1;
        tick();
        ExtIAck = 1'b0;
    endtask

    task automatic eret();
        ERet = 1'b1;
        tick();
        ERet = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = 4'b0010; mask_we = 1'b0; mask_wdata = '0;
        ExtIAck = 1'b0; ERet = 1'b0;
        tick(3);
        check("rst_extirq", 8'(ExtIRQ), 8'd0);
        check("rst_id",     8'(irq_id), 8'd0);
        check("rst_mask",   8'(irq_mask), 8'hf);
        check("rst_lost",   8'(irq_lost), 8'd0);

        // Line 1 held high across reset release must not request.
        reset = 1'b0;
        write_mask(4'b0000);
        tick(8);
        check("held_high_quiet", 8'(ExtIRQ), 8'd0);
        irq_in = '0;
        tick(5);
        check("fall_quiet", 8'(ExtIRQ), 8'd0);

        // Single request on line 2: latency k+3, ack, ERet.
        pulse(4'b0100);
        tick(2);
        check("lat_k2_low", 8'(ExtIRQ), 8'd0);
        tick();
        check("lat_k3_irq", 8'(ExtIRQ), 8'd1);
        check("lat_k3_id",  8'(irq_id), 8'd2);
        eret();
        check("eret_in_req_ignored", 8'(ExtIRQ), 8'd1);
        ack();
        check("ack_drops_irq", 8'(ExtIRQ), 8'd0);
        ack();
        eret();
        tick(2);
        check("idle_after_eret", 8'(ExtIRQ), 8'd0);

        // Lines 1 and 3 together: 1 first, 3 after ack+ERet, no nesting.
        pulse(4'b1010);
        tick(3);
        check("prio_irq", 8'(ExtIRQ), 8'd1);
        check("prio_id1", 8'(irq_id), 8'd1);
        ack();
        tick();
        check("no_nesting", 8'(ExtIRQ), 8'd0);
        eret();
        check("eret_cycle_low", 8'(ExtIRQ), 8'd0);
        tick();
        check("second_irq", 8'(ExtIRQ), 8'd1);
        check("second_id3", 8'(irq_id), 8'd3);
        ack();
        eret();
        tick(2);

        // Masked line 2 stays pending; unmasking requests it.
        write_mask(4'b0100);
        check("mask_loaded", 8'(irq_mask), 8'h4);
        pulse(4'b0100);
        tick(5);
        check("masked_quiet", 8'(ExtIRQ), 8'd0);
        write_mask(4'b0000);
        check("unmask_same_edge", 8'(ExtIRQ), 8'd0);
        tick();
        check("unmask_irq", 8'(ExtIRQ), 8'd1);
        check("unmask_id2", 8'(irq_id), 8'd2);
        pulse(4'b0001);
        write_mask(4'b1111);
        tick(3);
        check("req_mask_hold_irq", 8'(ExtIRQ), 8'd1);
        check("req_mask_hold_id",  8'(irq_id), 8'd2);
        check("req_mask_reg",      8'(irq_mask), 8'hf);
        ack();
        eret();
        // Line 0 pended while masked; clear it through a normal service.
        write_mask(4'b0000);
        tick();
        check("pend0_irq", 8'(ExtIRQ), 8'd1);
        check("pend0_id",  8'(irq_id), 8'd0);
        ack();
        eret();
        tick(2);
        check("lost_still_clear", 8'(irq_lost), 8'd0);

        // Edge on line 0 coincident with its ack: pending survives, no lost.
        pulse(4'b0001);
        tick(3);
        check("l0_id", 8'(irq_id), 8'd0);
        pulse(4'b0001);
        tick();
        ack();
        check("coinc_lost0", 8'(irq_lost), 8'd0);
        eret();
        tick();
        check("coinc_repend_irq", 8'(ExtIRQ), 8'd1);
        check("coinc_repend_id",  8'(irq_id), 8'd0);
        // Second edge on pending line 0 while in REQ sets irq_lost.
        pulse(4'b0001);
        tick(2);
        check("lost_set", 8'(irq_lost), 8'd1);
        check("lost_still_req", 8'(ExtIRQ), 8'd1);
        ack();
        eret();
        tick(4);
        check("lost_sticky", 8'(irq_lost), 8'd1);

        // Reset while in SERVICE for line 1.
        pulse(4'b0010);
        tick(5);
        check("l1_id", 8'(irq_id), 8'd1);
        ack();
        reset = 1'b1;
        tick();
        check("mid_rst_extirq", 8'(ExtIRQ), 8'd0);
        check("mid_rst_id",     8'(irq_id), 8'd0);
        check("mid_rst_mask",   8'(irq_mask), 8'hf);
        check("mid_rst_lost",   8'(irq_lost), 8'd0);
        reset = 1'b0;
        tick(4);
        write_mask(4'b0000);
        tick(3);
        check("post_rst_quiet", 8'(ExtIRQ), 8'd0);
        pulse(4'b1000);
        tick(3);
        check("post_rst_irq", 8'(ExtIRQ), 8'd1);
        check("post_rst_id3", 8'(irq_id), 8'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
